// File: rtl/rx.sv
// UART receiver: 8N1 with optional odd/even parity; 2-flop input synchronizer, mid-bit sampling.
// Latency: valid pulses 1 clk after the mid-stop-bit decision; the decision is 1 clk later with RX_MAJORITY_EN.
// Backpressure: none; the consumer must take rx_data on the 1-clk valid pulse (rx_data holds until next frame).
// Optional feature macro: RX_MAJORITY_EN (2-of-3 vote of samples at mid-1, mid, mid+1).
module rx #(
    parameter int parity    = 0,    // 0 = none, 1 = odd, 2 = even
    parameter int div_ratio = 434   // bit period minus 1, in clk cycles; >= 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(div_ratio + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(div_ratio);
`ifdef RX_MAJORITY_EN
    // Vote needs the sample after mid, so the decision point moves one clk later.
    localparam logic [CW-1:0] SAMP_PT = CW'(div_ratio / 2 + 1);
`else
    localparam logic [CW-1:0] SAMP_PT = CW'(div_ratio / 2);
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          valid_q, valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;
    logic          bit_s;
    logic          samp;
    logic          start_edge;

`ifdef RX_MAJORITY_EN
    logic rx_prev2_q;

    // Keep the two previous synchronized samples for the 2-of-3 vote.
    always_ff @(posedge clk) begin
        if (rst) rx_prev2_q <= 1'b1;
        else     rx_prev2_q <= rx_prev_q;
    end

    // Majority of samples at mid-1, mid, mid+1 (current clk is mid+1).
    always_comb begin
        bit_s = (rx_s_q & rx_prev_q) | (rx_s_q & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
    end
`else
    // Single sample at mid-bit.
    always_comb begin
        bit_s = rx_s_q;
    end
`endif

    assign samp       = (cnt_q == SAMP_PT);
    // Previous sample is registered every clk, so an edge in the clk of IDLE entry is not lost.
    assign start_edge = rx_prev_q & ~rx_s_q;

    // Next-state and output computation for the receive FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (samp) begin
                    if (!bit_s) begin
                        bitcnt_d = 3'd0;
                        state_d  = DATA;
                    end else begin
                        // Start bit not low at mid: treat as a glitch.
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (samp) begin
                    shift_d  = {bit_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = (parity != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (samp) begin
                    perr_d  = (parity == 1) ? ~(^shift_q ^ bit_s) : (^shift_q ^ bit_s);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (samp) begin
                    rx_data_d    = shift_q;
                    parity_err_d = (parity != 0) ? perr_q : 1'b0;
                    frame_err_d  = ~bit_s;
                    valid_d      = 1'b1;
                    if (bit_s) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Break condition: ignore the line until it returns high.
                cnt_d = '0;
                if (rx_s_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Synchronizer, edge-detect history and FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bitcnt_q     <= 3'd0;
            shift_q      <= 8'h00;
            perr_q       <= 1'b0;
            rx_data_q    <= 8'h00;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= rx_line;
            rx_s_q       <= sync1_q;
            rx_prev_q    <= rx_s_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx: two instances (no parity, odd parity), div_ratio = 9 (10-clk bits).
// A transmitter-model task drives serial frames; a monitor logs every valid pulse.
module tb_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       line0, line1;
    logic [7:0] d0, d1;
    logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int vcyc0 = 0;
    int c0;

    logic [7:0] q_data0[$];
    logic [7:0] q_data1[$];
    logic       q_pe0[$];
    logic       q_fe0[$];
    logic       q_pe1[$];
    logic       q_fe1[$];

`ifdef RX_MAJORITY_EN
    localparam int LAT = 99;
`else
    localparam int LAT = 98;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx #(.parity(0), .div_ratio(9)) dut0 (
        .clk(clk), .rst(rst), .rx_line(line0), .rx_data(d0), .valid(v0),
        .parity_err(pe0), .frame_err(fe0), .busy(b0)
    );

    rx #(.parity(1), .div_ratio(9)) dut1 (
        .clk(clk), .rst(rst), .rx_line(line1), .rx_data(d1), .valid(v1),
        .parity_err(pe1), .frame_err(fe1), .busy(b1)
    );

    // Log each valid pulse; a stuck valid shows up as extra entries.
    always @(negedge clk) begin
        if (v0) begin
            q_data0.push_back(d0);
            q_pe0.push_back(pe0);
            q_fe0.push_back(fe0);
            vcyc0 = cyc;
        end
        if (v1) begin
            q_data1.push_back(d1);
            q_pe1.push_back(pe1);
            q_fe1.push_back(fe1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) line1 = v;
        else     line0 = v;
    endtask

    // Drive the first nbits bits of a frame, 10 clks each; optional 1-clk low spike at clk 5 of spike_bit.
    task automatic send(input bit sel, input logic [7:0] data, input int nbits, input bit has_par,
                        input logic par_bit, input logic stop_bit, input int spike_bit);
        logic b[11];
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = data[i];
        b[9]  = has_par ? par_bit : stop_bit;
        b[10] = stop_bit;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 10; c++) begin
                set_line(sel, (i == spike_bit && c == 5) ? 1'b0 : b[i]);
                tick(1);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        line0 = 1'b1;
        line1 = 1'b1;
        tick(3);
        check("rst_data0",  {24'd0, d0}, 32'h00);
        check("rst_valid0", {31'd0, v0}, 32'd0);
        check("rst_busy0",  {31'd0, b0}, 32'd0);
        check("rst_fe0",    {31'd0, fe0}, 32'd0);
        check("rst_pe0",    {31'd0, pe0}, 32'd0);
        check("rst_data1",  {24'd0, d1}, 32'h00);
        check("rst_valid1", {31'd0, v1}, 32'd0);
        check("rst_busy1",  {31'd0, b1}, 32'd0);
        rst = 1'b0;
        tick(5);

        // 1: plain frame 0xA5, no parity
        c0 = cyc;
        send(1'b0, 8'hA5, 10, 1'b0, 1'b0, 1'b1, -1);
        tick(2);
        check("t1_count",   q_data0.size(), 1);
        check("t1_data",    {24'd0, q_data0[0]}, 32'hA5);
        check("t1_perr",    {31'd0, q_pe0[0]}, 32'd0);
        check("t1_ferr",    {31'd0, q_fe0[0]}, 32'd0);
        check("t1_latency", vcyc0 - c0, LAT);
        check("t1_busy",    {31'd0, b0}, 32'd0);
        tick(10);

        // 2: odd parity, 0x07 with correct parity bit 0, then flipped
        send(1'b1, 8'h07, 11, 1'b1, 1'b0, 1'b1, -1);
        tick(2);
        check("t2_count_a", q_data1.size(), 1);
        check("t2_data_a",  {24'd0, q_data1[0]}, 32'h07);
        check("t2_perr_a",  {31'd0, q_pe1[0]}, 32'd0);
        check("t2_ferr_a",  {31'd0, q_fe1[0]}, 32'd0);
        tick(10);
        send(1'b1, 8'h07, 11, 1'b1, 1'b1, 1'b1, -1);
        tick(2);
        check("t2_count_b", q_data1.size(), 2);
        check("t2_data_b",  {24'd0, q_data1[1]}, 32'h07);
        check("t2_perr_b",  {31'd0, q_pe1[1]}, 32'd1);
        tick(10);

        // 3: stop bit 0 and line held low (break)
        send(1'b0, 8'h55, 10, 1'b0, 1'b0, 1'b0, -1);
        tick(30);
        check("t3_count",   q_data0.size(), 2);
        check("t3_data",    {24'd0, q_data0[1]}, 32'h55);
        check("t3_ferr",    {31'd0, q_fe0[1]}, 32'd1);
        check("t3_busy_lo", {31'd0, b0}, 32'd1);
        line0 = 1'b1;
        tick(5);
        check("t3_busy_hi", {31'd0, b0}, 32'd0);
        check("t3_no_spur", q_data0.size(), 2);
        tick(10);

        // 4: 3-clk low glitch on idle line
        line0 = 1'b0;
        tick(3);
        line0 = 1'b1;
        tick(2);
        check("t4_busy_set", {31'd0, b0}, 32'd1);
        tick(20);
        check("t4_busy_clr", {31'd0, b0}, 32'd0);
        check("t4_no_valid", q_data0.size(), 2);
        tick(10);

        // 5: back-to-back 0x00 then 0xFF
        send(1'b0, 8'h00, 10, 1'b0, 1'b0, 1'b1, -1);
        send(1'b0, 8'hFF, 10, 1'b0, 1'b0, 1'b1, -1);
        tick(2);
        check("t5_count",  q_data0.size(), 4);
        check("t5_data_a", {24'd0, q_data0[2]}, 32'h00);
        check("t5_data_b", {24'd0, q_data0[3]}, 32'hFF);
        check("t5_ferr_a", {31'd0, q_fe0[2]}, 32'd0);
        check("t5_ferr_b", {31'd0, q_fe0[3]}, 32'd0);
        tick(10);

        // 6: reset in the middle of DATA of 0x3C, then 0x81
        send(1'b0, 8'h3C, 4, 1'b0, 1'b0, 1'b1, -1);
        rst   = 1'b1;
        line0 = 1'b1;
        tick(1);
        check("t6_rst_data",  {24'd0, d0}, 32'h00);
        check("t6_rst_busy",  {31'd0, b0}, 32'd0);
        check("t6_rst_valid", {31'd0, v0}, 32'd0);
        rst = 1'b0;
        tick(5);
        check("t6_no_partial", q_data0.size(), 4);
        send(1'b0, 8'h81, 10, 1'b0, 1'b0, 1'b1, -1);
        tick(2);
        check("t6_count", q_data0.size(), 5);
        check("t6_data",  {24'd0, q_data0[4]}, 32'h81);
        check("t6_ferr",  {31'd0, q_fe0[4]}, 32'd0);
        tick(10);

`ifdef RX_MAJORITY_EN
        // Majority: 1-clk low spike at mid of data bit 2 of 0xFF
        send(1'b0, 8'hFF, 10, 1'b0, 1'b0, 1'b1, 3);
        tick(2);
        check("maj_count", q_data0.size(), 6);
        check("maj_data",  {24'd0, q_data0[5]}, 32'hFF);
        tick(10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
